// File: rtl/game_status_ctrl_pkg.sv
// Shared definitions for the game status block: state encoding, status word
// width, default constants and a saturating-add helper.
package game_status_ctrl_pkg;

  localparam int STAT_W        = 13;
  localparam int DEF_LIFE_INIT = 3;
  localparam int DEF_SCORE_MAX = 999;

  typedef logic [STAT_W-1:0] stat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // The sum is formed one bit wider so a large increment can never wrap past the ceiling.
  function automatic stat_t sat_add(stat_t a, stat_t inc, stat_t max_val);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return (sum > {1'b0, max_val}) ? max_val : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/game_status_ctrl_frame_latch.sv
// Frame-synchronous copy of three status words: values are captured only on a
// rising edge of vsync so a downstream overlay never sees a mid-frame change.
module game_status_ctrl_frame_latch
  import game_status_ctrl_pkg::*;
#(
  parameter logic [2:0][STAT_W-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_i,
  input  logic [2:0][STAT_W-1:0]  val_i,
  output logic [2:0][STAT_W-1:0]  val_o
);

  logic vsync_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      val_o   <= RST_VAL;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_i && !vsync_q) begin
        val_o <= val_i;
      end
    end
  end

endmodule

// File: rtl/game_status_ctrl.sv
// Game-state bookkeeping: saturating score/lives/level counters driven by event
// pulses, an IDLE/RUN/OVER FSM, and frame-latched copies for the overlay.
module game_status_ctrl
  import game_status_ctrl_pkg::*;
#(
  parameter int LIFE_INIT   = DEF_LIFE_INIT,
  parameter int LIFE_MAX    = 9,
  parameter int SCORE_MAX   = DEF_SCORE_MAX,
  parameter int LVL_MAX     = 99,
  parameter int HIT_PTS     = 10,
  parameter int PTS_PER_LVL = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hit,
  input  logic              miss,
  input  logic              bonus,
  input  logic              vsync_in,
  output logic [STAT_W-1:0] score,
  output logic [STAT_W-1:0] life,
  output logic [STAT_W-1:0] lvl,
  output logic              running,
  output logic              game_over
);

  state_e state_q, state_d;
  stat_t  score_q, score_d;
  stat_t  life_q,  life_d;
  stat_t  lvl_q,   lvl_d;
  stat_t  thr_q,   thr_d;
  logic   running_d, game_over_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    life_d  = life_q;
    lvl_d   = lvl_q;
    thr_d   = thr_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          score_d = '0;
          life_d  = STAT_W'(LIFE_INIT);
          lvl_d   = STAT_W'(1);
          thr_d   = STAT_W'(PTS_PER_LVL);
        end
      end
      ST_RUN: begin
        if (life_q == '0) begin
          state_d = ST_OVER;
        end else begin
          // Level-up uses the registered score, so it lands one cycle after the crossing.
          if (score_q >= thr_q && lvl_q < STAT_W'(LVL_MAX)) begin
            lvl_d = lvl_q + STAT_W'(1);
            thr_d = thr_q + STAT_W'(PTS_PER_LVL);
          end
          if (hit) begin
            score_d = sat_add(score_q, STAT_W'(HIT_PTS), STAT_W'(SCORE_MAX));
          end
          if (bonus && !miss) begin
            life_d = sat_add(life_q, STAT_W'(1), STAT_W'(LIFE_MAX));
          end else if (miss && !bonus) begin
            life_d = life_q - STAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      life_q    <= STAT_W'(LIFE_INIT);
      lvl_q     <= STAT_W'(1);
      thr_q     <= STAT_W'(PTS_PER_LVL);
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      life_q    <= life_d;
      lvl_q     <= lvl_d;
      thr_q     <= thr_d;
      running   <= running_d;
      game_over <= game_over_d;
    end
  end

  logic [2:0][STAT_W-1:0] disp;

  game_status_ctrl_frame_latch #(
    .RST_VAL({STAT_W'(1), STAT_W'(LIFE_INIT), STAT_W'(0)})
  ) u_frame_latch (
    .clk     (clk),
    .rst     (rst),
    .vsync_i (vsync_in),
    .val_i   ({lvl_q, life_q, score_q}),
    .val_o   (disp)
  );

  assign score = disp[0];
  assign life  = disp[1];
  assign lvl   = disp[2];

endmodule

// File: tb/tb_game_status_ctrl.sv
// Self-checking bench for game_status_ctrl: a behavioural model pushes the
// expected outputs of every cycle to a scoreboard that is popped after the edge.
module tb_game_status_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, hit, miss, bonus, vsync_in;
  logic [12:0] score, life, lvl;
  logic        running, game_over;

  always #5 clk = ~clk;

  game_status_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .bonus     (bonus),
    .vsync_in  (vsync_in),
    .score     (score),
    .life      (life),
    .lvl       (lvl),
    .running   (running),
    .game_over (game_over)
  );

  typedef struct {
    int score;
    int life;
    int lvl;
    int run;
    int over;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: 0 idle, 1 run, 2 over
  int m_state, m_score, m_life, m_lvl, m_thr, m_vs;
  int o_score, o_life, o_lvl;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_life = 3; m_lvl = 1; m_thr = 100; m_vs = 0;
    o_score = 0; o_life = 3; o_lvl = 1;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (vsync_in && m_vs == 0) begin
      o_score = m_score; o_life = m_life; o_lvl = m_lvl;
    end
    m_vs = vsync_in;
    if (m_state != 1) begin
      if (start) begin
        m_state = 1; m_score = 0; m_life = 3; m_lvl = 1; m_thr = 100;
      end
    end else if (m_life == 0) begin
      m_state = 2;
    end else begin
      if (m_score >= m_thr && m_lvl < 99) begin
        m_lvl++;
        m_thr += 100;
      end
      if (hit) m_score = (m_score + 10 > 999) ? 999 : m_score + 10;
      if (bonus && !miss) m_life = (m_life + 1 > 9) ? 9 : m_life + 1;
      if (miss && !bonus) m_life = m_life - 1;
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic cyc(input logic s, input logic h, input logic m, input logic b, input logic v);
    exp_t e;
    exp_t got;
    start = s; hit = h; miss = m; bonus = b; vsync_in = v;
    @(posedge clk);
    model_edge();
    e.score = o_score; e.life = o_life; e.lvl = o_lvl;
    e.run = (m_state == 1) ? 1 : 0;
    e.over = (m_state == 2) ? 1 : 0;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check("score", int'(score), got.score);
    check("life", int'(life), got.life);
    check("lvl", int'(lvl), got.lvl);
    check("running", int'(running), got.run);
    check("game_over", int'(game_over), got.over);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic frame();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; start = 0; hit = 0; miss = 0; bonus = 0; vsync_in = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_score", int'(score), 0);
    check("rst_life", int'(life), 3);
    check("rst_lvl", int'(lvl), 1);
    rst = 1'b0;

    // Events in IDLE are ignored
    cyc(0, 1, 1, 1, 0);
    idle(1);
    frame();
    check("idle_score", int'(score), 0);
    check("idle_run", int'(running), 0);

    // Start, three hits: outputs hold until the frame edge
    cyc(1, 0, 0, 0, 0);
    hits(3);
    idle(2);
    check("pre_vs_score", int'(score), 0);
    frame();
    check("plan1_score", int'(score), 30);
    check("plan1_life", int'(life), 3);
    check("plan1_run", int'(running), 1);

    // Event on the copy edge shows only in the next frame
    cyc(0, 1, 0, 0, 1);
    check("same_edge_score", int'(score), 30);
    cyc(0, 0, 0, 0, 0);
    frame();
    check("next_frame_score", int'(score), 40);

    // Cross 100: level lands one cycle after the crossing
    hits(5);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("cross_score", int'(score), 100);
    check("cross_lvl_late", int'(lvl), 1);
    cyc(0, 0, 0, 0, 0);
    frame();
    check("cross_lvl", int'(lvl), 2);

    // Life arithmetic: bonus+miss cancel, saturation at 9
    cyc(0, 0, 1, 1, 0);
    frame();
    check("bm_life", int'(life), 3);
    hits(0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    frame();
    check("life_sat", int'(life), 9);

    // Fatal miss with a hit in the same cycle
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("fatal_still_run", int'(running), 1);
    cyc(0, 0, 0, 0, 0);
    check("over_flag", int'(game_over), 1);
    check("over_run", int'(running), 0);
    hits(3);
    cyc(0, 0, 0, 1, 0);
    frame();
    check("over_score", int'(score), 110);
    check("over_life", int'(life), 0);

    // Restart from OVER, then saturate score
    cyc(1, 0, 0, 0, 0);
    frame();
    check("restart_score", int'(score), 0);
    check("restart_life", int'(life), 3);
    check("restart_lvl", int'(lvl), 1);
    hits(100);
    idle(12);
    frame();
    check("sat_score", int'(score), 999);
    check("sat_lvl", int'(lvl), 10);

    // Mid-game reset at score 450
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0);
    hits(45);
    idle(2);
    frame();
    check("pre_rst_score", int'(score), 450);
    rst = 1'b1;
    cyc(0, 1, 0, 0, 0);
    rst = 1'b0;
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_life", int'(life), 3);
    check("mid_rst_lvl", int'(lvl), 1);
    check("mid_rst_run", int'(running), 0);
    check("mid_rst_over", int'(game_over), 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
